// File: rtl/riscv_pipe_pkg.sv
// Shared IF/ID pipeline types: bubble encoding and the default-width IF->ID beat.
package riscv_pipe_pkg;

    localparam int          PIPE_DATA_SIZE = 32;
    localparam int          PIPE_ADDR_SIZE = 10;
    localparam logic [31:0] NOP_INST       = 32'h00000013;

    // Byte PC is two bits wider than the word address.
    typedef struct packed {
        logic [PIPE_ADDR_SIZE+1:0] pc;
        logic [PIPE_DATA_SIZE-1:0] inst;
        logic [PIPE_ADDR_SIZE+1:0] pc4;
    } if_id_beat_t;

endpackage

// File: rtl/if_id_slot.sv
// One valid+payload register of the IF/ID stage; flush beats load, load beats clear.
// Only inst is forced to the bubble encoding when the slot empties; PCs keep their last value.
module if_id_slot
    import riscv_pipe_pkg::*;
#(
    parameter int                   DATA_SIZE = 32,
    parameter int                   ADDR_SIZE = 10,
    parameter logic [DATA_SIZE-1:0] NOP_INST  = riscv_pipe_pkg::NOP_INST
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   load_i,
    input  logic                   clear_i,
    input  logic [ADDR_SIZE+1:0]   pc_i,
    input  logic [DATA_SIZE-1:0]   inst_i,
    input  logic [ADDR_SIZE+1:0]   pc4_i,
    output logic                   valid_o,
    output logic [ADDR_SIZE+1:0]   pc_o,
    output logic [DATA_SIZE-1:0]   inst_o,
    output logic [ADDR_SIZE+1:0]   pc4_o
);

    logic                 valid_q, valid_d;
    logic [ADDR_SIZE+1:0] pc_q, pc_d;
    logic [DATA_SIZE-1:0] inst_q, inst_d;
    logic [ADDR_SIZE+1:0] pc4_q, pc4_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        if (flush_i) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            inst_d  = inst_i;
            pc4_d   = pc4_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            pc4_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
    assign pc4_o   = pc4_q;

endmodule

// File: rtl/if_id_pipe_stage.sv
// IF->ID pipeline stage with valid/ready handshake, flush and bubble insertion.
// Define IF_ID_SKID_EN for a 2-entry buffer with registered in_ready; otherwise a single slot.
module if_id_pipe_stage
    import riscv_pipe_pkg::*;
#(
    parameter int                   DATA_SIZE = 32,
    parameter int                   ADDR_SIZE = 10,
    parameter logic [DATA_SIZE-1:0] NOP_INST  = riscv_pipe_pkg::NOP_INST
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_SIZE+1:0] pc_if,
    input  logic [DATA_SIZE-1:0] inst_if,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_SIZE+1:0] pc_id,
    output logic [DATA_SIZE-1:0] inst_id,
    output logic [ADDR_SIZE+1:0] pc4_id
);

    localparam int PC_W = ADDR_SIZE + 2;

    logic            accept;
    logic [PC_W-1:0] pc4_if;
    logic            out_load;
    logic [PC_W-1:0] load_pc;
    logic [DATA_SIZE-1:0] load_inst;
    logic [PC_W-1:0] load_pc4;

    assign pc4_if = pc_if + PC_W'(4);
    assign accept = in_valid && in_ready;

`ifdef IF_ID_SKID_EN
    logic                 skid_valid;
    logic [PC_W-1:0]      skid_pc;
    logic [DATA_SIZE-1:0] skid_inst;
    logic [PC_W-1:0]      skid_pc4;
    logic                 out_adv;

    // in_ready depends only on the skid register, so out_ready never reaches it combinationally.
    assign in_ready  = !skid_valid;
    assign out_adv   = !out_valid || out_ready;
    assign out_load  = out_adv && (skid_valid || accept);
    assign load_pc   = skid_valid ? skid_pc   : pc_if;
    assign load_inst = skid_valid ? skid_inst : inst_if;
    assign load_pc4  = skid_valid ? skid_pc4  : pc4_if;

    if_id_slot #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE),
        .NOP_INST  (NOP_INST)
    ) u_skid_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .load_i  (accept && !out_adv),
        .clear_i (skid_valid && out_adv),
        .pc_i    (pc_if),
        .inst_i  (inst_if),
        .pc4_i   (pc4_if),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .inst_o  (skid_inst),
        .pc4_o   (skid_pc4)
    );
`else
    assign in_ready  = !out_valid || out_ready;
    assign out_load  = accept;
    assign load_pc   = pc_if;
    assign load_inst = inst_if;
    assign load_pc4  = pc4_if;
`endif

    if_id_slot #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE),
        .NOP_INST  (NOP_INST)
    ) u_out_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .load_i  (out_load),
        .clear_i (out_ready),
        .pc_i    (load_pc),
        .inst_i  (load_inst),
        .pc4_i   (load_pc4),
        .valid_o (out_valid),
        .pc_o    (pc_id),
        .inst_o  (inst_id),
        .pc4_o   (pc4_id)
    );

endmodule
